ofb_ctr_stream: RTL

Parametrised streaming OFB/CTR cipher-mode engine, the multi-block successor to the single-block OFB decrypt wrapper. It drives an external block-cipher core through a load/done handshake and chains it in OFB (output feedback) or CTR (counter) mode. Keystream blocks are prefetched into a small FIFO and XORed with a valid/ready data stream. The block is symmetric, so the same instance encrypts and decrypts. It sits between the AES core (key already applied there) and the packet datapath.

---
 rtl/ofb_ctr_stream.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ofb_ctr_stream.sv
// Streaming OFB/CTR cipher-mode engine: drives an external block-cipher core,
// prefetches keystream blocks into a small FIFO and XORs them onto a data stream.
module ofb_ctr_stream #(
  parameter int BLK_W = 128,
  parameter int CNT_W = 32,
  parameter int DEPTH = 4,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [BLK_W-1:0] iv,
  input  logic [LEN_W-1:0] nblk,
  output logic             busy,
  output logic             done,
  output logic             core_ld,
  output logic [BLK_W-1:0] core_in,
  input  logic             core_done,
  input  logic [BLK_W-1:0] core_out,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [BLK_W-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [BLK_W-1:0] m_data,
  output logic [2:0]       fsm_state
);

  // Both streams use valid/ready: a beat transfers on a rising edge where
  // valid and ready are both high; valid never waits on ready.

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

  state_t           state;
  logic             mode_r;
  logic [BLK_W-1:0] fb_r;
  logic [LEN_W-1:0] nblk_r;
  logic [LEN_W-1:0] issued;
  logic [LEN_W-1:0] consumed;
  logic [BLK_W-1:0] fifo_mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_after;
  logic [LEN_W-1:0] issued_next;
  logic             push;
  logic             pop;
  logic             last_accept;

  assign push        = (state == S_WAIT) && core_done;
  assign s_ready     = (count != '0) && (!m_valid || m_ready);
  assign pop         = s_valid && s_ready;
  assign count_after = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign issued_next = issued + LEN_W'(1);
  // Every block has been consumed, so the one leaving the output register is the last.
  assign last_accept = (state == S_DRAIN) && m_valid && m_ready && (consumed == nblk_r);

  assign busy      = (state != S_IDLE);
  assign core_ld   = (state == S_REQ);
  assign core_in   = fb_r;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= core_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      mode_r   <= 1'b0;
      fb_r     <= '0;
      nblk_r   <= '0;
      issued   <= '0;
      consumed <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      done     <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
    end else begin
      done  <= 1'b0;
      count <= count_after;

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        issued <= issued_next;
        if (mode_r) fb_r[CNT_W-1:0] <= fb_r[CNT_W-1:0] + CNT_W'(1);
        else        fb_r <= core_out;
      end

      if (pop) begin
        m_data   <= s_data ^ fifo_mem[rd_ptr];
        m_valid  <= 1'b1;
        rd_ptr   <= rd_ptr + 1'b1;
        consumed <= consumed + LEN_W'(1);
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            if (nblk == '0) begin
              done <= 1'b1;
            end else begin
              fb_r     <= iv;
              mode_r   <= mode;
              nblk_r   <= nblk;
              issued   <= '0;
              consumed <= '0;
              state    <= S_REQ;
            end
          end
        end
        S_REQ: state <= S_WAIT;
        S_WAIT: begin
          if (core_done) begin
            if (issued_next < nblk_r) state <= (count_after != FULL) ? S_REQ : S_HOLD;
            else                      state <= S_DRAIN;
          end
        end
        S_HOLD: begin
          if (count != FULL) state <= S_REQ;
        end
        S_DRAIN: begin
          if (last_accept) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
